systolic_tile_controller: RTL and testbench

Parametrised successor to the single-pass systolic array controller. It sequences 1..MAX_TILES back-to-back matrix tiles through an ARRAY_SIZE x ARRAY_SIZE systolic array, generating input-buffer addresses, ALU enable, and result row/tile write indices. New capabilities are stall (backpressure from the result SRAM), synchronous abort, a busy flag and a one-cycle done pulse. It sits between the TPU top-level sequencer and the systolic array / result SRAM.

---
 rtl/systolic_ctrl_pkg.sv | 31 +++
 rtl/systolic_tile_controller_if.sv | 38 +++
 rtl/systolic_tile_controller.sv | 130 +++++++++++++
 tb/tb_systolic_tile_controller.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_ctrl_pkg.sv
// rtl/systolic_ctrl_pkg.sv - shared state encoding, width helpers and timing constants for the tile controller
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    ROLL = 3'd3,
    DONE = 3'd4
  } state_e;

  // Result rows start draining one cycle after the array has filled.
  localparam int WRITE_START_OFFSET = 1;

  function automatic int addr_w(input int n);
    return $clog2(3 * n);
  endfunction

  function automatic int cyc_w(input int n);
    return $clog2(2 * n + 1);
  endfunction

  function automatic int row_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int tile_w(input int m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/systolic_tile_controller_if.sv
// rtl/systolic_tile_controller_if.sv - job control and array/SRAM sequencing signals of the tile controller
interface systolic_tile_controller_if
  import systolic_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE = 32,
  parameter int MAX_TILES  = 4
);
  localparam int ADDR_W = addr_w(ARRAY_SIZE);
  localparam int CYC_W  = cyc_w(ARRAY_SIZE);
  localparam int ROW_W  = row_w(ARRAY_SIZE);
  localparam int TILE_W = tile_w(MAX_TILES);

  logic              start;
  logic [TILE_W-1:0] num_tiles_m1;
  logic              stall;
  logic              abort;
  logic              busy;
  logic [ADDR_W-1:0] addr_serial_num;
  logic              alu_en;
  logic [CYC_W-1:0]  cycle_num;
  logic [ROW_W-1:0]  row_index;
  logic [TILE_W-1:0] tile_index;
  logic              sram_write_enable;
  logic              done;

  modport master (
    output start, num_tiles_m1, stall, abort,
    input  busy, addr_serial_num, alu_en, cycle_num, row_index, tile_index,
           sram_write_enable, done
  );

  modport slave (
    input  start, num_tiles_m1, stall, abort,
    output busy, addr_serial_num, alu_en, cycle_num, row_index, tile_index,
           sram_write_enable, done
  );

endinterface

// File: rtl/systolic_tile_controller.sv
// rtl/systolic_tile_controller.sv - sequences 1..MAX_TILES tiles through an NxN systolic array with stall and abort
module systolic_tile_controller
  import systolic_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE = 32,
  parameter int MAX_TILES  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  systolic_tile_controller_if.slave    bus
);
  localparam int N      = ARRAY_SIZE;
  localparam int ADDR_W = addr_w(N);
  localparam int CYC_W  = cyc_w(N);
  localparam int ROW_W  = row_w(N);
  localparam int TILE_W = tile_w(MAX_TILES);

  localparam logic [CYC_W-1:0]  WR_START = CYC_W'(N + WRITE_START_OFFSET);
  localparam logic [CYC_W-1:0]  LAST_CYC = CYC_W'(N + WRITE_START_OFFSET + N - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(3 * N - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(N - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CYC_W-1:0]  r_cyc;
  logic [ROW_W-1:0]  r_row;
  logic [TILE_W-1:0] r_tile;
  logic [TILE_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_done;

  state_e            w_state_nx;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [CYC_W-1:0]  w_cyc_nx;
  logic [ROW_W-1:0]  w_row_nx;
  logic [TILE_W-1:0] w_tile_nx;
  logic [TILE_W-1:0] w_cnt_nx;
  logic              w_roll_go;
  logic              w_wr;

  assign w_roll_go = (r_state == ROLL) && !bus.stall;
  assign w_wr      = w_roll_go && (r_cyc >= WR_START);

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_cyc_nx   = r_cyc;
    w_row_nx   = r_row;
    w_tile_nx  = r_tile;
    w_cnt_nx   = r_cnt;
    if (bus.abort) begin
      w_state_nx = IDLE;
      w_addr_nx  = '0;
      w_cyc_nx   = '0;
      w_row_nx   = '0;
      w_tile_nx  = '0;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          w_state_nx = LOAD;
          w_cnt_nx   = bus.num_tiles_m1;
          w_tile_nx  = '0;
          w_addr_nx  = '0;
          w_cyc_nx   = '0;
          w_row_nx   = '0;
        end
        LOAD: begin
          w_state_nx = WAIT;
          w_addr_nx  = ADDR_W'(1);
        end
        WAIT: begin
          w_state_nx = ROLL;
          w_addr_nx  = ADDR_W'(2);
          w_cyc_nx   = '0;
        end
        ROLL: if (w_roll_go) begin
          w_cyc_nx  = r_cyc + CYC_W'(1);
          w_addr_nx = (r_addr == ADDR_MAX) ? r_addr : r_addr + ADDR_W'(1);
          if (w_wr) w_row_nx = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
          // Last row written: wrap into the next tile or finish the job.
          if (r_cyc == LAST_CYC) begin
            w_cyc_nx  = '0;
            w_addr_nx = '0;
            if (r_tile < r_cnt) begin
              w_state_nx = LOAD;
              w_tile_nx  = r_tile + TILE_W'(1);
            end else begin
              w_state_nx = DONE;
            end
          end
        end
        DONE: w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cyc   <= '0;
      r_row   <= '0;
      r_tile  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_cyc   <= w_cyc_nx;
      r_row   <= w_row_nx;
      r_tile  <= w_tile_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= (w_state_nx != IDLE);
      r_done  <= (w_state_nx == DONE);
    end
  end

  assign bus.busy              = r_busy;
  assign bus.done              = r_done;
  assign bus.addr_serial_num   = r_addr;
  assign bus.cycle_num         = r_cyc;
  assign bus.row_index         = r_row;
  assign bus.tile_index        = r_tile;
  assign bus.alu_en            = w_roll_go;
  assign bus.sram_write_enable = w_wr;

endmodule

// File: tb/tb_systolic_tile_controller.sv
// tb/tb_systolic_tile_controller.sv - directed self-checking bench for the tile controller (N=4 and N=32 instances)
module tb_systolic_tile_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  systolic_tile_controller_if #(.ARRAY_SIZE(4),  .MAX_TILES(4)) s ();
  systolic_tile_controller_if #(.ARRAY_SIZE(32), .MAX_TILES(4)) b ();

  systolic_tile_controller #(.ARRAY_SIZE(4),  .MAX_TILES(4)) u_small (.clk(clk), .rst_n(rst_n), .bus(s));
  systolic_tile_controller #(.ARRAY_SIZE(32), .MAX_TILES(4)) u_big   (.clk(clk), .rst_n(rst_n), .bus(b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_small(input int m1);
    s.num_tiles_m1 = 2'(m1);
    s.start = 1'b1;
    tick();
    s.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s.start = 0; s.stall = 0; s.abort = 0; s.num_tiles_m1 = 0;
    b.start = 0; b.stall = 0; b.abort = 0; b.num_tiles_m1 = 0;
    tick(); tick(); #1;
    n_checks++;
    if ({s.busy, s.alu_en, s.sram_write_enable, s.done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {s.busy, s.alu_en, s.sram_write_enable, s.done});
    end
    n_checks++;
    if ({s.addr_serial_num, s.cycle_num, s.row_index, s.tile_index} !== 12'd0) begin
      n_fail++; $display("FAIL reset_counters got addr=%0d cyc=%0d row=%0d tile=%0d exp 0",
                         s.addr_serial_num, s.cycle_num, s.row_index, s.tile_index);
    end
    n_checks++;
    if ({b.busy, b.done, b.addr_serial_num, b.cycle_num} !== 16'd0) begin
      n_fail++; $display("FAIL reset_big got busy=%b done=%b addr=%0d cyc=%0d exp 0", b.busy, b.done, b.addr_serial_num, b.cycle_num);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_tile();
    int wr = 0;
    logic [3:0] ef;
    int ec;
    accept_small(0);
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) tick();
      #1;
      ef = {k <= 12, k >= 3 && k <= 11, k >= 8 && k <= 11, k == 12};
      ec = (k >= 3 && k <= 11) ? k - 3 : 0;
      n_checks++;
      if ({s.busy, s.alu_en, s.sram_write_enable, s.done} !== ef) begin
        n_fail++; $display("FAIL single_flags k=%0d got %b exp %b", k, {s.busy, s.alu_en, s.sram_write_enable, s.done}, ef);
      end
      n_checks++;
      if (int'(s.cycle_num) != ec) begin
        n_fail++; $display("FAIL single_cycle k=%0d got %0d exp %0d", k, s.cycle_num, ec);
      end
      if (k <= 11) begin
        n_checks++;
        if (int'(s.addr_serial_num) != k - 1) begin
          n_fail++; $display("FAIL single_addr k=%0d got %0d exp %0d", k, s.addr_serial_num, k - 1);
        end
      end
      if (s.sram_write_enable === 1'b1) begin
        wr++;
        n_checks++;
        if (int'(s.row_index) != k - 8) begin
          n_fail++; $display("FAIL single_row k=%0d got %0d exp %0d", k, s.row_index, k - 8);
        end
      end
    end
    n_checks++;
    if (wr != 4) begin
      n_fail++; $display("FAIL single_writes got %0d exp 4", wr);
    end
  endtask

  task automatic test_multi_tile();
    int wr = 0, dn = 0, t, p;
    logic [3:0] ef;
    accept_small(2);
    s.num_tiles_m1 = 2'd0;
    for (int k = 1; k <= 35; k++) begin
      if (k > 1) tick();
      #1;
      t = (k - 1) / 11;
      p = (k - 1) % 11 + 1;
      if (k <= 33) ef = {1'b1, p >= 3, p >= 8, 1'b0};
      else         ef = {k == 34, 1'b0, 1'b0, k == 34};
      n_checks++;
      if ({s.busy, s.alu_en, s.sram_write_enable, s.done} !== ef) begin
        n_fail++; $display("FAIL multi_flags k=%0d got %b exp %b", k, {s.busy, s.alu_en, s.sram_write_enable, s.done}, ef);
      end
      if (k <= 33) begin
        n_checks++;
        if (int'(s.tile_index) != t) begin
          n_fail++; $display("FAIL multi_tile k=%0d got %0d exp %0d", k, s.tile_index, t);
        end
        n_checks++;
        if (int'(s.addr_serial_num) != p - 1) begin
          n_fail++; $display("FAIL multi_addr k=%0d got %0d exp %0d", k, s.addr_serial_num, p - 1);
        end
        if (p >= 8) begin
          n_checks++;
          if (int'(s.row_index) != p - 8) begin
            n_fail++; $display("FAIL multi_row k=%0d got %0d exp %0d", k, s.row_index, p - 8);
          end
        end
      end
      if (s.sram_write_enable === 1'b1) wr++;
      if (s.done === 1'b1) dn++;
    end
    n_checks++;
    if (wr != 12 || dn != 1) begin
      n_fail++; $display("FAIL multi_counts got writes=%0d dones=%0d exp 12 1", wr, dn);
    end
  endtask

  task automatic test_stall();
    int wr = 0, ec, k_st;
    logic roll, st;
    logic [3:0] ef;
    accept_small(0);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick();
      st = (k >= 9 && k <= 11);
      s.stall = st;
      #1;
      roll = (k >= 3 && k <= 14);
      ec = !roll ? 0 : (k < 9) ? k - 3 : (k <= 11) ? 6 : k - 6;
      ef = {k <= 15, roll && !st, roll && !st && ec >= 5, k == 15};
      n_checks++;
      if ({s.busy, s.alu_en, s.sram_write_enable, s.done} !== ef) begin
        n_fail++; $display("FAIL stall_flags k=%0d got %b exp %b", k, {s.busy, s.alu_en, s.sram_write_enable, s.done}, ef);
      end
      n_checks++;
      if (int'(s.cycle_num) != ec) begin
        n_fail++; $display("FAIL stall_cycle k=%0d got %0d exp %0d", k, s.cycle_num, ec);
      end
      if (roll) begin
        k_st = (ec >= 5) ? ec - 5 + (st ? 0 : 0) : 0;
        n_checks++;
        if (int'(s.addr_serial_num) != ec + 2) begin
          n_fail++; $display("FAIL stall_addr k=%0d got %0d exp %0d", k, s.addr_serial_num, ec + 2);
        end
        if (ec >= 5) begin
          n_checks++;
          if (int'(s.row_index) != k_st) begin
            n_fail++; $display("FAIL stall_row k=%0d got %0d exp %0d", k, s.row_index, k_st);
          end
        end
      end
      if (s.sram_write_enable === 1'b1) wr++;
    end
    s.stall = 1'b0;
    n_checks++;
    if (wr != 4) begin
      n_fail++; $display("FAIL stall_writes got %0d exp 4", wr);
    end
  endtask

  task automatic test_abort();
    int dn = 0;
    accept_small(1);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) tick();
      s.abort = (k == 20);
      #1;
    end
    n_checks++;
    if (int'(s.cycle_num) != 6 || int'(s.tile_index) != 1 || int'(s.row_index) != 1) begin
      n_fail++; $display("FAIL abort_pre got cyc=%0d tile=%0d row=%0d exp 6 1 1", s.cycle_num, s.tile_index, s.row_index);
    end
    tick();
    s.abort = 1'b0;
    #1;
    n_checks++;
    if ({s.busy, s.alu_en, s.sram_write_enable, s.done} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_flags got %b exp 0000", {s.busy, s.alu_en, s.sram_write_enable, s.done});
    end
    n_checks++;
    if ({s.addr_serial_num, s.cycle_num, s.row_index, s.tile_index} !== 12'd0) begin
      n_fail++; $display("FAIL abort_counters got addr=%0d cyc=%0d row=%0d tile=%0d exp 0",
                         s.addr_serial_num, s.cycle_num, s.row_index, s.tile_index);
    end
    for (int k = 0; k < 15; k++) begin
      tick(); #1;
      if (s.done === 1'b1 || s.busy === 1'b1) dn++;
    end
    n_checks++;
    if (dn != 0) begin
      n_fail++; $display("FAIL abort_idle got %0d active cycles exp 0", dn);
    end
    accept_small(0);
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) tick();
      #1;
      n_checks++;
      if ({s.busy, s.done} !== {k <= 12, k == 12}) begin
        n_fail++; $display("FAIL restart k=%0d got busy=%b done=%b exp %b %b", k, s.busy, s.done, k <= 12, k == 12);
      end
    end
  endtask

  task automatic test_start_conflicts();
    s.start = 1'b1;
    s.abort = 1'b1;
    tick();
    s.start = 1'b0;
    s.abort = 1'b0;
    #1;
    n_checks++;
    if ({s.busy, s.done} !== 2'b00) begin
      n_fail++; $display("FAIL start_abort got busy=%b done=%b exp 0 0", s.busy, s.done);
    end
    accept_small(0);
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) tick();
      s.start = (k == 5);
      s.num_tiles_m1 = (k == 5) ? 2'd3 : 2'd0;
      #1;
      n_checks++;
      if ({s.busy, s.done} !== {k <= 12, k == 12} || s.tile_index !== 2'd0) begin
        n_fail++; $display("FAIL start_in_roll k=%0d got busy=%b done=%b tile=%0d exp %b %b 0",
                           k, s.busy, s.done, s.tile_index, k <= 12, k == 12);
      end
      if (k == 6) begin
        n_checks++;
        if (int'(s.cycle_num) != 3) begin
          n_fail++; $display("FAIL start_in_roll_cyc got %0d exp 3", s.cycle_num);
        end
      end
    end
  endtask

  task automatic test_reset_midjob();
    accept_small(1);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      #1;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({s.busy, s.alu_en, s.addr_serial_num, s.cycle_num, s.row_index, s.tile_index} !== 14'd0) begin
      n_fail++; $display("FAIL reset_midjob got busy=%b alu=%b addr=%0d cyc=%0d row=%0d tile=%0d exp 0",
                         s.busy, s.alu_en, s.addr_serial_num, s.cycle_num, s.row_index, s.tile_index);
    end
    tick(); #1;
    n_checks++;
    if (s.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_midjob_idle got busy=%b exp 0", s.busy);
    end
  endtask

  task automatic test_big_array();
    int wr = 0, ec;
    logic roll;
    logic [3:0] ef;
    b.num_tiles_m1 = 2'd0;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (k > 1) tick();
      #1;
      roll = (k >= 3 && k <= 67);
      ec = roll ? k - 3 : 0;
      ef = {k <= 68, roll, roll && ec >= 33, k == 68};
      n_checks++;
      if ({b.busy, b.alu_en, b.sram_write_enable, b.done} !== ef || int'(b.cycle_num) != ec) begin
        n_fail++; $display("FAIL big_flags k=%0d got %b cyc=%0d exp %b cyc=%0d",
                           k, {b.busy, b.alu_en, b.sram_write_enable, b.done}, b.cycle_num, ef, ec);
      end
      if (roll) begin
        n_checks++;
        if (int'(b.addr_serial_num) != ec + 2 || int'(b.addr_serial_num) > 95) begin
          n_fail++; $display("FAIL big_addr k=%0d got %0d exp %0d", k, b.addr_serial_num, ec + 2);
        end
      end
      if (b.sram_write_enable === 1'b1) begin
        wr++;
        n_checks++;
        if (int'(b.row_index) != ec - 33) begin
          n_fail++; $display("FAIL big_row k=%0d got %0d exp %0d", k, b.row_index, ec - 33);
        end
      end
    end
    n_checks++;
    if (wr != 32) begin
      n_fail++; $display("FAIL big_writes got %0d exp 32", wr);
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_stall();
    test_abort();
    test_start_conflicts();
    test_reset_midjob();
    test_big_array();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
